// File: rtl/jt7759_seq.sv
`default_nettype none
// =============================================================================
// Module : jt7759_seq
// Brief  : ADPCM phrase sequencer. Walks the phrase table, fetches commands
//          and streams nibbles to the decoder. Defining JT7759_REPEAT_EN
//          enables the repeat command (0xC0-0xFF).
// Rev    : 1.0
// =============================================================================
module jt7759_seq (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen_ctl,
    input  logic        cen_dec,
    input  logic        stn,
    input  logic [7:0]  phrase,
    output logic        busyn,
    output logic        ctrl_cs,
    output logic [16:0] ctrl_addr,
    input  logic [7:0]  ctrl_din,
    input  logic        ctrl_ok,
    output logic        ctrl_flush,
    output logic        dec_rst,
    output logic        dec_stb,
    output logic [3:0]  dec_nibble
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        RD_CNT = 4'd1,
        RD_HI  = 4'd2,
        RD_LO  = 4'd3,
        RD_CMD = 4'd4,
        SILENT = 4'd5,
        RD_LEN = 4'd6,
        PLAY   = 4'd7,
        RD_REP = 4'd8
    } state_t;

    state_t      r_state;
    logic        r_stn_l;
    logic        r_busyn;
    logic        r_cs;
    logic        r_flush;
    logic        r_dec_rst;
    logic        r_stb;
    logic [3:0]  r_nibble;
    logic [16:0] r_addr;
    logic [16:0] r_start;
    logic [7:0]  r_phrase;
    logic [7:0]  r_hi;
    logic [7:0]  r_byte;
    logic [10:0] r_cnt;
    logic        r_have;
    logic        r_half;

    logic        w_start;
    logic        w_got;
    logic        w_rd;
    logic        w_cmd_end;

`ifdef JT7759_REPEAT_EN
    logic [2:0]  r_cmd3;
    logic [2:0]  r_rep;
    logic        r_rep_act;
    logic [2:0]  w_rep;

    assign w_rep     = r_rep_act ? r_rep : r_cmd3;
    assign w_cmd_end = (ctrl_din == 8'h00);
`else
    assign w_cmd_end = (ctrl_din == 8'h00) || (ctrl_din[7:6] == 2'b11);
`endif

    assign w_start = cen_ctl & r_stn_l & ~stn;
    assign w_got   = cen_ctl & r_cs & ctrl_ok;
    assign w_rd    = (r_state == RD_CNT) || (r_state == RD_HI) || (r_state == RD_LO) ||
                     (r_state == RD_CMD) || (r_state == RD_LEN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_stn_l   <= 1'b1;
            r_busyn   <= 1'b1;
            r_cs      <= 1'b0;
            r_flush   <= 1'b0;
            r_dec_rst <= 1'b0;
            r_stb     <= 1'b0;
            r_nibble  <= 4'd0;
            r_addr    <= 17'd0;
            r_start   <= 17'd0;
            r_phrase  <= 8'd0;
            r_hi      <= 8'd0;
            r_byte    <= 8'd0;
            r_cnt     <= 11'd0;
            r_have    <= 1'b0;
            r_half    <= 1'b0;
`ifdef JT7759_REPEAT_EN
            r_cmd3    <= 3'd0;
            r_rep     <= 3'd0;
            r_rep_act <= 1'b0;
`endif
        end else begin
            r_flush   <= 1'b0;
            r_dec_rst <= 1'b0;
            r_stb     <= 1'b0;
            if (cen_ctl) r_stn_l <= stn;

            if (w_start) begin
                // A new start always wins, aborting whatever fetch is in flight
                r_phrase  <= phrase;
                r_busyn   <= 1'b0;
                r_cs      <= 1'b0;
                r_addr    <= 17'd0;
                r_cnt     <= 11'd0;
                r_have    <= 1'b0;
                r_flush   <= (r_state != IDLE);
                r_state   <= RD_CNT;
`ifdef JT7759_REPEAT_EN
                r_rep_act <= 1'b0;
`endif
            end else begin
                if (w_rd) begin
                    if (cen_ctl && !r_cs) r_cs <= 1'b1;
                    if (w_got) begin
                        r_cs   <= 1'b0;
                        r_addr <= r_addr + 17'd1;
                    end
                end

                case (r_state)
                    RD_CNT: if (w_got) begin
                        if (r_phrase > ctrl_din) begin
                            r_state <= IDLE;
                            r_busyn <= 1'b1;
                        end else begin
                            r_state <= RD_HI;
                            r_addr  <= 17'd5 + {8'd0, r_phrase, 1'b0};
                        end
                    end
                    RD_HI: if (w_got) begin
                        r_hi    <= ctrl_din;
                        r_state <= RD_LO;
                    end
                    RD_LO: if (w_got) begin
                        r_start   <= {r_hi, ctrl_din, 1'b0};
                        r_addr    <= {r_hi, ctrl_din, 1'b0};
                        r_dec_rst <= 1'b1;
                        r_state   <= RD_CMD;
                    end
                    RD_CMD: if (w_got) begin
                        if (w_cmd_end) begin
                            r_state <= IDLE;
                            r_busyn <= 1'b1;
                            r_flush <= 1'b1;
                        end else begin
                            case (ctrl_din[7:6])
                                2'b00: begin
                                    r_cnt   <= {ctrl_din[5:0], 5'd0};
                                    r_state <= SILENT;
                                end
                                2'b01: begin
                                    r_cnt   <= 11'd256;
                                    r_have  <= 1'b0;
                                    r_state <= PLAY;
                                end
                                2'b10: r_state <= RD_LEN;
                                default: begin
`ifdef JT7759_REPEAT_EN
                                    r_cmd3  <= ctrl_din[2:0];
                                    r_state <= RD_REP;
`else
                                    r_state <= IDLE;
`endif
                                end
                            endcase
                        end
                    end
                    SILENT: begin
                        if (cen_dec && r_cnt != 11'd0) begin
                            r_stb    <= 1'b1;
                            r_nibble <= 4'd0;
                            r_cnt    <= r_cnt - 11'd1;
                        end
                        if (cen_ctl && r_cnt == 11'd0) r_state <= RD_CMD;
                    end
                    RD_LEN: if (w_got) begin
                        r_cnt   <= {3'd0, ctrl_din} + 11'd1;
                        r_have  <= 1'b0;
                        r_state <= PLAY;
                    end
                    PLAY: begin
                        // One byte buffered at most; the next fetch waits for its low nibble
                        if (w_got) begin
                            r_byte <= ctrl_din;
                            r_have <= 1'b1;
                            r_half <= 1'b0;
                            r_cs   <= 1'b0;
                            r_addr <= r_addr + 17'd1;
                        end else if (cen_ctl && !r_have && !r_cs) begin
                            if (r_cnt != 11'd0) r_cs <= 1'b1;
                            else                r_state <= RD_CMD;
                        end
                        if (cen_dec && r_have) begin
                            r_stb    <= 1'b1;
                            r_nibble <= r_half ? r_byte[3:0] : r_byte[7:4];
                            r_half   <= ~r_half;
                            r_cnt    <= r_cnt - 11'd1;
                            if (r_half || r_cnt == 11'd1) r_have <= 1'b0;
                        end
                    end
`ifdef JT7759_REPEAT_EN
                    RD_REP: if (cen_ctl) begin
                        r_state <= RD_CMD;
                        if (w_rep != 3'd0) begin
                            r_rep     <= w_rep - 3'd1;
                            r_rep_act <= 1'b1;
                            r_addr    <= r_start;
                        end else begin
                            r_rep_act <= 1'b0;
                        end
                    end
`endif
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign busyn      = r_busyn;
    assign ctrl_cs    = r_cs;
    assign ctrl_addr  = r_addr;
    assign ctrl_flush = r_flush;
    assign dec_rst    = r_dec_rst;
    assign dec_stb    = r_stb;
    assign dec_nibble = r_nibble;

endmodule
`default_nettype wire

// File: tb/tb_jt7759_seq.sv
`default_nettype none
// =============================================================================
// Module : tb_jt7759_seq
// Brief  : Self-checking bench for jt7759_seq: ROM responder with random
//          latency, nibble monitor and a command-interpreting reference model.
// Rev    : 1.0
// =============================================================================
module tb_jt7759_seq;

    logic        rst = 1'b1;
    logic        clk = 1'b0;
    logic        cen_ctl = 1'b0;
    logic        cen_dec = 1'b0;
    logic        stn = 1'b1;
    logic [7:0]  phrase = 8'd0;
    logic        busyn;
    logic        ctrl_cs;
    logic [16:0] ctrl_addr;
    logic [7:0]  ctrl_din = 8'd0;
    logic        ctrl_ok = 1'b0;
    logic        ctrl_flush;
    logic        dec_rst;
    logic        dec_stb;
    logic [3:0]  dec_nibble;

    jt7759_seq dut (
        .rst        (rst),
        .clk        (clk),
        .cen_ctl    (cen_ctl),
        .cen_dec    (cen_dec),
        .stn        (stn),
        .phrase     (phrase),
        .busyn      (busyn),
        .ctrl_cs    (ctrl_cs),
        .ctrl_addr  (ctrl_addr),
        .ctrl_din   (ctrl_din),
        .ctrl_ok    (ctrl_ok),
        .ctrl_flush (ctrl_flush),
        .dec_rst    (dec_rst),
        .dec_stb    (dec_stb),
        .dec_nibble (dec_nibble)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [0:131071];
    logic [3:0] got_q[$];
    logic [3:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int exp_rst = 0;
    int n_rst = 0, n_flush = 0, n_both = 0, n_addr_chg = 0, n_stb_win = 0, n_busy = 0;
    bit stall = 1'b0;
    bit win_en = 1'b0;

    initial begin : cen_gen
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            cen_ctl = ($urandom_range(0, 3) != 0);
            cen_dec = (ph == 0);
            ph = (ph + 1) % 4;
        end
    end

    initial begin : mem_model
        int lat;
        logic [16:0] held;
        bit held_v;
        lat = 0; held = '0; held_v = 1'b0;
        forever begin
            @(negedge clk);
            if (ctrl_cs && !rst) begin
                if (held_v && ctrl_addr !== held) n_addr_chg++;
                held = ctrl_addr; held_v = 1'b1;
                if (stall) ctrl_ok = 1'b0;
                else if (lat == 0) begin
                    ctrl_ok  = 1'b1;
                    ctrl_din = rom[ctrl_addr];
                end else lat--;
            end else begin
                ctrl_ok = 1'b0;
                held_v  = 1'b0;
                lat     = $urandom_range(0, 3);
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (dec_rst) begin n_rst++; got_q.delete(); end
            if (dec_stb) got_q.push_back(dec_nibble);
            if (dec_stb && dec_rst) n_both++;
            if (ctrl_flush) n_flush++;
            if (win_en && dec_stb) n_stb_win++;
            if (!busyn) n_busy++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: interpret the phrase's command stream straight from the ROM image
    task automatic model_run(input logic [7:0] p);
        logic [16:0] a, st;
        logic [7:0] c, b;
        int n, rep;
        bit act;
        exp_q.delete();
        exp_rst = 0;
        if (p > rom[0]) return;
        exp_rst = 1;
        st = {rom[5 + 2 * p], rom[6 + 2 * p], 1'b0};
        a = st; rep = 0; act = 1'b0;
        for (int guard = 0; guard < 4096; guard++) begin
            c = rom[a];
            a = a + 17'd1;
            if (c == 8'h00) break;
            if (c < 8'h40) begin
                for (int i = 0; i < 32 * c[5:0]; i++) exp_q.push_back(4'd0);
                continue;
            end
            if (c < 8'h80) n = 256;
            else if (c < 8'hC0) begin
                n = rom[a] + 1;
                a = a + 17'd1;
            end else begin
`ifdef JT7759_REPEAT_EN
                if (!act) begin rep = c[2:0]; act = 1'b1; end
                if (rep != 0) begin rep--; a = st; end
                else act = 1'b0;
                continue;
`else
                break;
`endif
            end
            for (int i = 0; i < n; i++) begin
                b = rom[17'(a + i / 2)];
                exp_q.push_back((i % 2 == 0) ? b[7:4] : b[3:0]);
            end
            a = 17'(a + (n + 1) / 2);
        end
    endtask

    task automatic start_phrase(input logic [7:0] p);
        int k;
        phrase = p;
        stn = 1'b0;
        k = 0;
        do begin @(posedge clk); k++; end while (!cen_ctl && k < 50);
        #1;
        stn = 1'b1;
        do begin @(posedge clk); k++; end while (!cen_ctl && k < 100);
        #1;
        if (k >= 100) check("stn_sync_timeout", 0, 1);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int k;
        k = 0;
        while (!busyn && k < bound) begin tick(); k++; end
        if (k >= bound) check({tag, "_timeout"}, 0, 1);
        repeat (3) tick();
    endtask

    task automatic wait_nibbles(input string tag, input int cnt);
        int k;
        k = 0;
        while (got_q.size() < cnt && k < 5000) begin tick(); k++; end
        if (k >= 5000) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic cmp_q(input string tag);
        int nb;
        nb = 0;
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) nb++;
        check({tag, "_nib_errs"}, nb, 0);
    endtask

    task automatic run_phrase(input string tag, input logic [7:0] p);
        got_q.delete();
        n_rst = 0;
        n_flush = 0;
        model_run(p);
        start_phrase(p);
        wait_idle(tag, 20000);
        cmp_q(tag);
        check({tag, "_dec_rst"}, n_rst, exp_rst);
    endtask

    task automatic set_table(input logic [7:0] p, input logic [16:0] base);
        rom[5 + 2 * p] = base[16:9];
        rom[6 + 2 * p] = base[8:1];
    endtask

    task automatic build_random(input logic [7:0] p, input logic [16:0] base);
        logic [16:0] a;
        int nc, l;
        a = base;
        set_table(p, base);
        nc = $urandom_range(1, 3);
        for (int k = 0; k < nc; k++) begin
            case ($urandom_range(0, 3))
                0: begin rom[a] = 8'h01; a++; end
                3: begin
                    rom[a] = 8'hC0 | 8'($urandom_range(0, 7) << 3) | 8'($urandom_range(0, 1));
                    a++;
                end
                default: begin
                    l = $urandom_range(0, 63);
                    rom[a] = 8'h80 | 8'($urandom_range(0, 63));
                    rom[a + 17'd1] = 8'(l);
                    a = a + 17'd2;
                    for (int j = 0; j < (l + 2) / 2; j++) begin
                        rom[a] = 8'($urandom);
                        a++;
                    end
                end
            endcase
        end
        rom[a] = 8'h00;
    endtask

    initial begin : stim
        int nb;
        int rep_n;
        for (int i = 0; i < 131072; i++) rom[i] = 8'h00;

        // Phrase 2 at 0x20: 0x41, 128 x 0xAB, 0x00
        rom[0] = 8'h02;
        rom[9] = 8'h00; rom[10] = 8'h10;
        rom[17'h20] = 8'h41;
        for (int i = 0; i < 128; i++) rom[17'h21 + i] = 8'hAB;
        rom[17'hA1] = 8'h00;

        repeat (4) tick();
        check("rst_busyn", busyn, 1);
        check("rst_cs", ctrl_cs, 0);
        rst = 1'b0;
        repeat (2) tick();
        check("rel_busyn", busyn, 1);
        check("rel_cs", ctrl_cs, 0);
        check("rel_addr", ctrl_addr, 0);
        check("rel_flush", ctrl_flush, 0);
        check("rel_dec_rst", dec_rst, 0);
        check("rel_dec_stb", dec_stb, 0);
        check("rel_nibble", dec_nibble, 0);

        run_phrase("ph2_play256", 8'd2);
        check("ph2_count", got_q.size(), 256);
        check("ph2_first", got_q.size() > 1 ? {got_q[0], got_q[1]} : 8'h00, 8'hAB);
        check("ph2_flush", n_flush, 1);

        // Out-of-range phrase: only the count fetch runs
        got_q.delete(); n_rst = 0; n_busy = 0;
        start_phrase(8'd3);
        wait_idle("ph3", 200);
        check("ph3_dec_rst", n_rst, 0);
        check("ph3_stb", got_q.size(), 0);
        check("ph3_busy_short", (n_busy > 0 && n_busy < 40), 1);

        rom[0] = 8'h09;
        rom[1] = 8'h00;

        set_table(8'd0, 17'h200);
        rom[17'h200] = 8'h82; rom[17'h201] = 8'h05; rom[17'h202] = 8'h9C;
        rom[17'h203] = 8'hD0; rom[17'h204] = 8'hE7; rom[17'h205] = 8'h00;
        run_phrase("len6", 8'd0);
        check("len6_count", got_q.size(), 6);

        set_table(8'd1, 17'h300);
        rom[17'h300] = 8'h02; rom[17'h301] = 8'h80; rom[17'h302] = 8'h01;
        rom[17'h303] = 8'h5A; rom[17'h304] = 8'h00;
        run_phrase("silent64", 8'd1);
        check("silent64_count", got_q.size(), 66);

        set_table(8'd4, 17'h400);
        rom[17'h400] = 8'h41;
        for (int i = 0; i < 128; i++) rom[17'h401 + i] = 8'($urandom);
        rom[17'h481] = 8'hC2;
        rom[17'h482] = 8'h00;
        run_phrase("repeat", 8'd4);
`ifdef JT7759_REPEAT_EN
        rep_n = 768;
`else
        rep_n = 256;
`endif
        check("repeat_total", got_q.size(), rep_n);

        // Long phrase 5 at 0x600 and short phrase 6 at 0x800
        set_table(8'd5, 17'h600);
        rom[17'h600] = 8'h40;
        for (int i = 0; i < 128; i++) rom[17'h601 + i] = 8'($urandom);
        rom[17'h681] = 8'h7F;
        for (int i = 0; i < 128; i++) rom[17'h682 + i] = 8'($urandom);
        rom[17'h702] = 8'h00;
        set_table(8'd6, 17'h800);
        rom[17'h800] = 8'h80; rom[17'h801] = 8'h0B;
        for (int i = 0; i < 6; i++) rom[17'h802 + i] = 8'($urandom);
        rom[17'h808] = 8'h00;

        // Fetch stall during PLAY
        got_q.delete(); n_rst = 0; n_flush = 0;
        model_run(8'd5);
        start_phrase(8'd5);
        wait_nibbles("stall_pre", 20);
        stall = 1'b1;
        repeat (12) tick();
        n_stb_win = 0;
        win_en = 1'b1;
        repeat (28) tick();
        win_en = 1'b0;
        stall = 1'b0;
        check("stall_no_stb", n_stb_win, 0);
        wait_idle("stall", 20000);
        cmp_q("stall");
        check("stall_dec_rst", n_rst, 1);

        // Restart mid-PLAY
        got_q.delete(); n_rst = 0; n_flush = 0;
        model_run(8'd5);
        start_phrase(8'd5);
        wait_nibbles("restart_pre", 30);
        nb = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) nb++;
        check("restart_prefix", nb, 0);
        n_flush = 0; n_rst = 0;
        model_run(8'd6);
        start_phrase(8'd6);
        wait_idle("restart", 20000);
        check("restart_flush", n_flush, 2);
        check("restart_dec_rst", n_rst, 1);
        cmp_q("restart_new");

        // Asynchronous reset mid-phrase, then a clean start
        got_q.delete();
        start_phrase(8'd5);
        wait_nibbles("midrst_pre", 10);
        rst = 1'b1;
        #1;
        check("midrst_busyn", busyn, 1);
        check("midrst_cs", ctrl_cs, 0);
        check("midrst_addr", ctrl_addr, 0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();
        run_phrase("after_rst", 8'd6);

        // Address counter wrap: start at 0x1FFFE, data byte read from 0x00000
        set_table(8'd7, 17'h1FFFE);
        rom[17'h1FFFE] = 8'h80;
        rom[17'h1FFFF] = 8'h01;
        run_phrase("wrap", 8'd7);
        check("wrap_count", got_q.size(), 2);

        for (int it = 0; it < 4; it++) begin
            build_random(8'd8, 17'h1000);
            run_phrase($sformatf("rand%0d", it), 8'd8);
        end

        check("stb_rst_overlap", n_both, 0);
        check("addr_stable_cs", n_addr_chg, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
